// File: rtl/caravel_mem_selftest.sv
// caravel_mem_selftest: RAM self-test engine using word, halfword and byte access phases.
// Progress and result codes are published on checkbits, which the external monitor sees.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   IDLE     | waiting for start, checkbits 0000
//   W_WR     | write word patterns to all N words
//   W_RD     | read back and compare word patterns (N+1 cycles)
//   W_OK     | word phase passed, hold AB41 for HOLD cycles
//   H_WR     | write halfword patterns to all 2N lanes
//   H_RD     | read back and compare halfword lanes (2N+1 cycles)
//   H_OK     | halfword phase passed, hold AB21 for HOLD cycles
//   B_WR     | write byte patterns to all 4N lanes
//   B_RD     | read back and compare byte lanes (4N+1 cycles)
//   PASS_ALL | every phase passed, sticky AB11
//   FAIL     | compare mismatch, sticky phase fail code
module caravel_mem_selftest #(
   parameter int ADDR_W = 6,
   parameter int HOLD   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        inject_fault,
   output logic [15:0] checkbits,
   output logic        done,
   output logic        pass
);

   localparam int N      = 2 ** ADDR_W;
   localparam int CNT_W  = ADDR_W + 3;
   localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

   localparam logic [1:0] SEL_WORD = 2'd0;
   localparam logic [1:0] SEL_HALF = 2'd1;
   localparam logic [1:0] SEL_BYTE = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE, S_W_WR, S_W_RD, S_W_OK, S_H_WR, S_H_RD, S_H_OK,
      S_B_WR, S_B_RD, S_PASS_ALL, S_FAIL
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [15:0]         checkbits_q, checkbits_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;

   logic [31:0]         mem_q [N];
   logic [31:0]         rdata_q;
   logic                ram_we;
   logic                ram_re;
   logic [3:0]          ram_be;
   logic [ADDR_W-1:0]   ram_addr;
   logic [31:0]         ram_wdata;

   logic [1:0]          sel;
   logic [CNT_W-1:0]    m_cnt;
   logic [CNT_W-1:0]    cmp_elem;
   logic [31:0]         exp_val;
   logic [31:0]         got_val;
   logic                mismatch;

   // Expected value of element e, right-aligned to its lane width.
   function automatic logic [31:0] lane_val(input logic [1:0] s, input logic [CNT_W-1:0] e);
      logic [15:0] e16;
      e16 = 16'(e);
      case (s)
         SEL_WORD: lane_val = {~e16, e16};
         SEL_HALF: lane_val = {16'h0000, 16'hC000 | {2'b00, e16[13:0]}};
         default:  lane_val = {24'h000000, e16[7:0] ^ 8'h5A};
      endcase
   endfunction

   // Lane value replicated across the word so the byte enables pick the right copy.
   function automatic logic [31:0] wdata_of(input logic [1:0] s, input logic [31:0] v);
      case (s)
         SEL_WORD: wdata_of = v;
         SEL_HALF: wdata_of = {2{v[15:0]}};
         default:  wdata_of = {4{v[7:0]}};
      endcase
   endfunction

   function automatic logic [3:0] be_of(input logic [1:0] s, input logic [1:0] lane);
      case (s)
         SEL_WORD: be_of = 4'hF;
         SEL_HALF: be_of = lane[0] ? 4'hC : 4'h3;
         default:  be_of = 4'b0001 << lane;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] s, input logic [CNT_W-1:0] e);
      case (s)
         SEL_WORD: addr_of = e[ADDR_W-1:0];
         SEL_HALF: addr_of = e[ADDR_W:1];
         default:  addr_of = e[ADDR_W+1:2];
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [1:0] s, input logic [1:0] lane,
                                           input logic [31:0] d);
      case (s)
         SEL_WORD: extract = d;
         SEL_HALF: extract = {16'h0000, lane[0] ? d[31:16] : d[15:0]};
         default:  extract = {24'h000000, d[{lane, 3'b000} +: 8]};
      endcase
   endfunction

   // Phase selection and the read-back compare; the fault flips bit 0 of the compared lane.
   always_comb begin
      sel = SEL_WORD;
      case (state_q)
         S_H_WR, S_H_RD: sel = SEL_HALF;
         S_B_WR, S_B_RD: sel = SEL_BYTE;
         default:        sel = SEL_WORD;
      endcase
      m_cnt    = CNT_W'(N) << sel;
      cmp_elem = cnt_q - CNT_W'(1);
      exp_val  = lane_val(sel, cmp_elem);
      got_val  = extract(sel, cmp_elem[1:0], rdata_q) ^ {31'b0, inject_fault};
      mismatch = (got_val != exp_val);
   end

   // Next-state, counters and RAM access control.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_be    = be_of(sel, cnt_q[1:0]);
      ram_addr  = addr_of(sel, cnt_q);
      ram_wdata = wdata_of(sel, lane_val(sel, cnt_q));
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) state_d = S_W_WR;
         end
         S_W_WR, S_H_WR, S_B_WR: begin
            ram_we = 1'b1;
            if (cnt_q == m_cnt - CNT_W'(1)) begin
               cnt_d = '0;
               case (state_q)
                  S_W_WR:  state_d = S_W_RD;
                  S_H_WR:  state_d = S_H_RD;
                  default: state_d = S_B_RD;
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_W_RD, S_H_RD, S_B_RD: begin
            ram_re = (cnt_q != m_cnt);
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q != '0 && mismatch) begin
               state_d = S_FAIL;
               cnt_d   = '0;
            end else if (cnt_q == m_cnt) begin
               cnt_d  = '0;
               hold_d = HOLD_W'(HOLD - 1);
               case (state_q)
                  S_W_RD:  state_d = S_W_OK;
                  S_H_RD:  state_d = S_H_OK;
                  default: state_d = S_PASS_ALL;
               endcase
            end
         end
         S_W_OK, S_H_OK: begin
            if (hold_q == '0) begin
               state_d = (state_q == S_W_OK) ? S_H_WR : S_B_WR;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   // Status code for the upcoming state; the fail code depends on the phase being left.
   always_comb begin
      checkbits_d = 16'h0000;
      case (state_d)
         S_W_WR, S_W_RD: checkbits_d = 16'hA040;
         S_W_OK:         checkbits_d = 16'hAB41;
         S_H_WR, S_H_RD: checkbits_d = 16'hA020;
         S_H_OK:         checkbits_d = 16'hAB21;
         S_B_WR, S_B_RD: checkbits_d = 16'hA010;
         S_PASS_ALL:     checkbits_d = 16'hAB11;
         S_FAIL: begin
            if (state_q == S_FAIL)      checkbits_d = checkbits_q;
            else if (sel == SEL_WORD)   checkbits_d = 16'hAB40;
            else if (sel == SEL_HALF)   checkbits_d = 16'hAB20;
            else                        checkbits_d = 16'hAB10;
         end
         default:        checkbits_d = 16'h0000;
      endcase
      done_d = (state_d == S_PASS_ALL) || (state_d == S_FAIL);
      pass_d = (state_d == S_PASS_ALL);
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         checkbits_q <= 16'h0000;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         checkbits_q <= checkbits_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   // Byte-enabled RAM with one-cycle read latency; contents survive reset.
   always_ff @(posedge clock) begin
      if (ram_we) begin
         for (int k = 0; k < 4; k++) begin
            if (ram_be[k]) mem_q[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
         end
      end
      if (ram_re) rdata_q <= mem_q[ram_addr];
   end

   assign checkbits = checkbits_q;
   assign done      = done_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_caravel_mem_selftest.sv
// Bench for caravel_mem_selftest: table of fault scenarios plus random fault cycles,
// each traced cycle by cycle against a phase-timeline model.
module tb_caravel_mem_selftest;

   localparam int N       = 64;
   localparam int HOLD    = 4;
   localparam int RUN_LEN = 915;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        inject_fault;
   logic [15:0] checkbits;
   logic        done;
   logic        pass;

   int total = 0;
   int bad   = 0;

   caravel_mem_selftest #(.ADDR_W(6), .HOLD(HOLD)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .inject_fault (inject_fault),
      .checkbits    (checkbits),
      .done         (done),
      .pass         (pass)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      int          ft;
      bit          hold_start;
      logic [15:0] final_cb;
      logic        final_pass;
   } vec_t;

   vec_t tbl[14];

   // Expected code at cycle t (0 = first W_WR cycle) when a single fault is injected at cycle ft.
   function automatic logic [15:0] exp_code(int t, int ft);
      int cur;
      int m;
      int rd_end;
      bit hit;
      logic [15:0] run_c, ok_c, fail_c;
      if (t < 0) return 16'h0000;
      cur = 0;
      for (int p = 0; p < 3; p++) begin
         m      = N << p;
         run_c  = (p == 0) ? 16'hA040 : (p == 1) ? 16'hA020 : 16'hA010;
         fail_c = (p == 0) ? 16'hAB40 : (p == 1) ? 16'hAB20 : 16'hAB10;
         ok_c   = (p == 0) ? 16'hAB41 : (p == 1) ? 16'hAB21 : 16'hAB11;
         rd_end = cur + 2 * m;
         hit    = (ft >= cur + m + 1) && (ft <= rd_end);
         if (hit) return (t <= ft) ? run_c : fail_c;
         if (t <= rd_end) return run_c;
         if (p == 2) return ok_c;
         if (t <= rd_end + HOLD) return ok_c;
         cur = rd_end + 1 + HOLD;
      end
      return 16'hAB11;
   endfunction

   function automatic logic [7:0] bpat(int b);
      logic [7:0] v;
      v = 8'(b);
      return v ^ 8'h5A;
   endfunction

   task automatic check(string name, logic [15:0] ec);
      logic ed, ep;
      ed = (ec == 16'hAB11) || (ec == 16'hAB40) || (ec == 16'hAB20) || (ec == 16'hAB10);
      ep = (ec == 16'hAB11);
      total++;
      if (checkbits !== ec || done !== ed || pass !== ep) begin
         bad++;
         $display("FAIL %s: got cb=%h done=%b pass=%b, want cb=%h done=%b pass=%b",
                  name, checkbits, done, pass, ec, ed, ep);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      inject_fault = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check("reset", 16'h0000);
   endtask

   // Launch from IDLE at the current negedge and trace len cycles against the model.
   task automatic run_trace(string name, int ft, bit hold_start, int len);
      start = 1'b1;
      for (int t = 0; t < len; t++) begin
         @(negedge clock);
         start = hold_start;
         check($sformatf("%s t=%0d", name, t), exp_code(t, ft));
         inject_fault = (t == ft);
      end
      inject_fault = 1'b0;
      start = 1'b0;
   endtask

   task automatic check_lanes();
      logic [31:0] want;
      logic [31:0] got;
      for (int j = 0; j < N; j++) begin
         want = {bpat(4*j+3), bpat(4*j+2), bpat(4*j+1), bpat(4*j)};
         got  = dut.mem_q[j];
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL lanes word %0d: got %h want %h", j, got, want);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      inject_fault = 1'b0;

      tbl[0]  = '{"no_fault",        -1,  1'b0, 16'hAB11, 1'b1};
      tbl[1]  = '{"w_elem5",         70,  1'b0, 16'hAB40, 1'b0};
      tbl[2]  = '{"w_last_cmp",      128, 1'b0, 16'hAB40, 1'b0};
      tbl[3]  = '{"w_rd_issue_only", 64,  1'b1, 16'hAB11, 1'b1};
      tbl[4]  = '{"w_ok_hold",       130, 1'b0, 16'hAB11, 1'b1};
      tbl[5]  = '{"h_first_cmp",     262, 1'b0, 16'hAB20, 1'b0};
      tbl[6]  = '{"h_rd_issue_only", 261, 1'b0, 16'hAB11, 1'b1};
      tbl[7]  = '{"h_ok_last",       393, 1'b0, 16'hAB11, 1'b1};
      tbl[8]  = '{"b_write",         500, 1'b0, 16'hAB11, 1'b1};
      tbl[9]  = '{"b_final_cmp",     906, 1'b1, 16'hAB10, 1'b0};
      tbl[10] = '{"b_first_cmp",     651, 1'b0, 16'hAB10, 1'b0};
      for (int i = 11; i < 14; i++) begin
         tbl[i].name       = $sformatf("random%0d", i);
         tbl[i].ft         = int'($urandom_range(0, 910));
         tbl[i].hold_start = 1'($urandom_range(0, 1));
         tbl[i].final_cb   = exp_code(5000, tbl[i].ft);
         tbl[i].final_pass = (tbl[i].final_cb == 16'hAB11);
      end

      do_reset();
      repeat (3) begin
         @(negedge clock);
         check("idle_hold", 16'h0000);
      end

      for (int i = 0; i < 14; i++) begin
         do_reset();
         run_trace(tbl[i].name, tbl[i].ft, tbl[i].hold_start, RUN_LEN);
         start = 1'b1;
         repeat (10) @(negedge clock);
         start = 1'b0;
         check({tbl[i].name, "_sticky"}, tbl[i].final_cb);
         total++;
         if (pass !== tbl[i].final_pass) begin
            bad++;
            $display("FAIL %s_pass: got %b want %b", tbl[i].name, pass, tbl[i].final_pass);
         end
      end

      // Reset in the middle of H_WR aborts, then a fresh start completes.
      do_reset();
      run_trace("mid_reset_pre", -1, 1'b0, 201);
      reset = 1'b1;
      @(negedge clock);
      check("mid_reset_abort", 16'h0000);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("mid_reset_idle", 16'h0000);
      end
      run_trace("mid_reset_rerun", -1, 1'b0, RUN_LEN);
      check("mid_reset_final", 16'hAB11);
      check_lanes();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
